mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 138 +++++++++++++
 tb/tb_mem_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-port word memory behind a valid/ready request port with a one-cycle response pulse.
// Define MEM_WAIT_EN to add a WAIT state that stretches every access by WAIT_CYCLES cycles.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
`ifdef MEM_WAIT_EN
    WAIT,
`endif
    RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_mem [DEPTH_WORDS];

`ifdef MEM_WAIT_EN
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  logic [3:0] r_wcnt;
`endif

  logic        w_accept;
  logic        w_enter_resp;
  logic        w_cur_we;
  logic [31:0] w_cur_addr;
  logic [31:0] w_cur_wdata;
  logic [3:0]  w_cur_be;
  logic        w_cur_fault;
  logic        w_fault;

  // Power-of-two depth: addr[31:2] >= DEPTH_WORDS is the same as any bit above the index being set.
  function automatic logic f_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
`ifdef MEM_WAIT_EN
          w_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
`else
          w_next = RESP;
`endif
        end
      end
`ifdef MEM_WAIT_EN
      WAIT:    if (r_wcnt == '0) w_next = RESP;
`endif
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = (r_state == IDLE);
    rsp_valid = (r_state == RESP);
    w_fault   = f_fault(r_addr);
    rsp_err   = rsp_valid && w_fault;
    rsp_rdata = '0;
    if (rsp_valid && !w_fault && !r_we) rsp_rdata = r_mem[r_addr[AW+1:2]];
  end

  // Request latch and wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
`ifdef MEM_WAIT_EN
      r_wcnt  <= '0;
`endif
    end else if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_be    <= req_be;
`ifdef MEM_WAIT_EN
      r_wcnt  <= WAIT_INIT;
    end else if (r_state == WAIT && r_wcnt != '0) begin
      r_wcnt  <= r_wcnt - 4'd1;
`endif
    end
  end

  // With no wait the store commits on the accept edge itself, before the latch holds it,
  // so the write path selects the live request while in IDLE.
  always_comb begin
    w_accept     = req_valid && req_ready;
    w_enter_resp = (r_state != RESP) && (w_next == RESP);
    w_cur_we     = (r_state == IDLE) ? req_we    : r_we;
    w_cur_addr   = (r_state == IDLE) ? req_addr  : r_addr;
    w_cur_wdata  = (r_state == IDLE) ? req_wdata : r_wdata;
    w_cur_be     = (r_state == IDLE) ? req_be    : r_be;
    w_cur_fault  = f_fault(w_cur_addr);
  end

  // Memory array: never reset; a reset edge must not commit a pending store.
  always_ff @(posedge clk) begin
    if (!rst && w_enter_resp && w_cur_we && !w_cur_fault) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_cur_be[b]) r_mem[w_cur_addr[AW+1:2]][8*b +: 8] <= w_cur_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder; latency expectations follow MEM_WAIT_EN.
module tb_mem_responder;
  localparam int unsigned DEPTH = 1024;
`ifdef MEM_WAIT_EN
  localparam int W = 2;
`else
  localparam int W = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  typedef struct packed { logic [31:0] rdata; logic err; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one request, scrambles inputs after accept, and reports the response and its latency.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, output logic [31:0] rdata, output logic err,
                     output int lat, output logic zero_ok);
    int n;
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    rdata = '0; err = 1'b0; lat = -1; zero_ok = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (rsp_valid) begin rdata = rsp_rdata; err = rsp_err; lat = i; break; end
      if (rsp_rdata !== '0 || rsp_err !== 1'b0) zero_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== '0 || rsp_err !== 1'b0)
      begin errors++; $display("FAIL reset_rsp got %h/%b want 0/0", rsp_rdata, rsp_err); end
    rst = 1'b0;
  endtask

  task automatic test_store_load();
    logic        we  [5] = '{1, 0, 1, 1, 0};
    logic [31:0] ad  [5] = '{32'h10, 32'h10, 32'h20, 32'hFFC, 32'hFFC};
    logic [31:0] wd  [5] = '{32'hDEADBEEF, 32'h0, 32'h11111111, 32'h12345678, 32'h0};
    logic [31:0] exd [5] = '{32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h12345678};
    logic [31:0] rd; logic er, zk; int lat; exp_t e;
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{rdata: exd[i], err: 1'b0});
      txn(we[i], ad[i], wd[i], 4'hF, rd, er, lat, zk);
      e = sb.pop_front();
      checks++; if (rd !== e.rdata || er !== e.err)
        begin errors++; $display("FAIL store_load[%0d] got %h/%b want %h/%b", i, rd, er, e.rdata, e.err); end
      checks++; if (lat !== W + 1) begin errors++; $display("FAIL store_load_lat[%0d] got %0d want %0d", i, lat, W + 1); end
      checks++; if (zk !== 1'b1) begin errors++; $display("FAIL store_load_idle_zero[%0d] got %b want 1", i, zk); end
    end
  endtask

  task automatic test_byte_enable();
    logic        we  [6] = '{1, 0, 1, 0, 1, 0};
    logic [31:0] ad  [6] = '{32'h10, 32'h10, 32'h10, 32'h10, 32'h20, 32'h20};
    logic [31:0] wd  [6] = '{32'h000000AA, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hA5A5A5A5, 32'h0};
    logic [3:0]  be  [6] = '{4'b0001, 4'hF, 4'b0000, 4'h0, 4'b0110, 4'h0};
    logic [31:0] exd [6] = '{32'h0, 32'hDEADBEAA, 32'h0, 32'hDEADBEAA, 32'h0, 32'h11A5A511};
    logic [31:0] rd; logic er, zk; int lat; exp_t e;
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{rdata: exd[i], err: 1'b0});
      txn(we[i], ad[i], wd[i], be[i], rd, er, lat, zk);
      e = sb.pop_front();
      checks++; if (rd !== e.rdata || er !== e.err)
        begin errors++; $display("FAIL byte_enable[%0d] got %h/%b want %h/%b", i, rd, er, e.rdata, e.err); end
    end
  endtask

  task automatic test_faults();
    logic        we  [7] = '{0, 1, 1, 1, 1, 0, 0};
    logic [31:0] ad  [7] = '{32'h13, 32'h1000, 32'h1010, 32'h12, 32'h80000010, 32'h10, 32'hFFC};
    logic        exe [7] = '{1, 1, 1, 1, 1, 0, 0};
    logic [31:0] exd [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hDEADBEAA, 32'h12345678};
    logic [31:0] rd; logic er, zk; int lat; exp_t e;
    for (int i = 0; i < 7; i++) begin
      sb.push_back('{rdata: exd[i], err: exe[i]});
      txn(we[i], ad[i], 32'hCAFEF00D, 4'hF, rd, er, lat, zk);
      e = sb.pop_front();
      checks++; if (rd !== e.rdata || er !== e.err)
        begin errors++; $display("FAIL fault[%0d] got %h/%b want %h/%b", i, rd, er, e.rdata, e.err); end
      checks++; if (lat !== W + 1) begin errors++; $display("FAIL fault_lat[%0d] got %0d want %0d", i, lat, W + 1); end
    end
  endtask

  task automatic test_latency();
    int lows, vidx, early;
    sb.push_back('{rdata: 32'hDEADBEAA, err: 1'b0});
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h10; req_be = 4'hF; req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    lows = 0; vidx = -1; early = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rsp_valid && vidx < 0) begin
        vidx = i;
        checks++; if (rsp_rdata !== sb[0].rdata || rsp_err !== sb[0].err)
          begin errors++; $display("FAIL latency_data got %h/%b want %h/%b", rsp_rdata, rsp_err, sb[0].rdata, sb[0].err); end
        void'(sb.pop_front());
      end
      if (req_ready) break;
      lows++;
    end
    checks++; if (vidx !== W + 1) begin errors++; $display("FAIL latency_valid got %0d want %0d", vidx, W + 1); end
    checks++; if (lows !== W + 1) begin errors++; $display("FAIL latency_ready_low got %0d want %0d", lows, W + 1); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic er, zk; int lat, seen; exp_t e;
    @(negedge clk);
    seen = 0;
`ifdef MEM_WAIT_EN
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h99999999; req_be = 4'hF; req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL abort_in_wait got ready %b want 0", req_ready); end
`else
    req_we = 1'b0; req_addr = 32'h10; req_be = 4'hF; req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL abort_in_resp got valid %b want 1", rsp_valid); end
`endif
    rst = 1'b1; #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== '0 || req_ready !== 1'b1)
      begin errors++; $display("FAIL abort_async got v%b d%h r%b want v0 d0 r1", rsp_valid, rsp_rdata, req_ready); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (rsp_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_rsp got %0d pulses want 0", seen); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b want 1", req_ready); end
`ifdef MEM_WAIT_EN
    sb.push_back('{rdata: 32'h11A5A511, err: 1'b0});
    txn(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat, zk);
`else
    sb.push_back('{rdata: 32'hDEADBEAA, err: 1'b0});
    txn(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat, zk);
`endif
    e = sb.pop_front();
    checks++; if (rd !== e.rdata || er !== e.err)
      begin errors++; $display("FAIL abort_word got %h/%b want %h/%b", rd, er, e.rdata, e.err); end
  endtask

  task automatic test_back_to_back();
    int cyc, acc, pulses, last, gap_bad;
    logic will_acc; exp_t e;
    repeat (3) sb.push_back('{rdata: 32'h12345678, err: 1'b0});
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'hFFC; req_be = 4'hF; req_valid = 1'b1;
    cyc = 0; acc = 0; pulses = 0; last = -1; gap_bad = 0;
    while (pulses < 3 && cyc < 60) begin
      cyc++;
      if (rsp_valid) begin
        e = sb.pop_front();
        checks++; if (rsp_rdata !== e.rdata || rsp_err !== e.err)
          begin errors++; $display("FAIL b2b_data[%0d] got %h/%b want %h/%b", pulses, rsp_rdata, rsp_err, e.rdata, e.err); end
        if (last >= 0 && cyc - last != 2 + W) gap_bad++;
        last = cyc; pulses++;
      end
      will_acc = req_valid && req_ready;
      @(posedge clk);
      if (will_acc) acc++;
      if (acc == 3) begin #1; req_valid = 1'b0; end
      @(negedge clk);
    end
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (rsp_valid) pulses++; end
    checks++; if (pulses !== 3) begin errors++; $display("FAIL b2b_count got %0d want 3", pulses); end
    checks++; if (gap_bad !== 0) begin errors++; $display("FAIL b2b_spacing got %0d bad gaps want 0 (spacing %0d)", gap_bad, 2 + W); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_enable();
    test_faults();
    test_latency();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
